// File: rtl/usb_sie_pkg.sv
// Shared types and protocol constants for the USB serial interface engine receive path.
package usb_sie_pkg;
    typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} rx_state_e;

    localparam int SYNC_MIN_ZEROS = 6;
    localparam int SYNC_MAX_ZEROS = 7;
    localparam int MAX_ONES       = 6;
    localparam int EOP_MIN_SE0    = 2;
endpackage

// File: rtl/usb_rx_byte_assembler.sv
// LSB-first byte shift register with bit counter; byte_out/byte_done present the completed byte
// combinationally on the strobe that shifts in the 8th bit.
module usb_rx_byte_assembler (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_en,
    input  logic       clear,
    input  logic       bit_in,
    output logic [7:0] byte_out,
    output logic       byte_done,
    output logic [2:0] bit_cnt
);
    logic [7:0] sr_q;
    logic [2:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (shift_en) begin
            sr_q  <= {bit_in, sr_q[7:1]};
            cnt_q <= cnt_q + 3'd1;
        end
    end

    assign byte_out  = {bit_in, sr_q[7:1]};
    assign byte_done = shift_en && (cnt_q == 3'd7);
    assign bit_cnt   = cnt_q;
endmodule

// File: rtl/usb_rx_sequencer.sv
// USB receive sequencer: SYNC detection, bit unstuffing control, byte framing, EOP and error tracking.
module usb_rx_sequencer
    import usb_sie_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_en,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             se0,
    output logic             en_unstuff,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic             pkt_active,
    output logic             pkt_done,
    output logic             err_stuff,
    output logic             err_len,
    output logic [CNT_W-1:0] byte_count
);
    rx_state_e        state_q;
    logic [2:0]       zcnt_q;
    logic [2:0]       ones_q;
    logic [1:0]       se0cnt_q;
    logic             err_se0_q;
    logic [7:0]       byte_out_q;
    logic             byte_valid_q, pkt_done_q, err_stuff_q, err_len_q;
    logic [CNT_W-1:0] cnt_q;

    logic       asm_shift, asm_clear, asm_done;
    logic [7:0] asm_byte;
    logic [2:0] asm_cnt;

    // Stuffed bits and SE0 strobes never reach the shift register.
    assign asm_shift = rx_en && bit_valid && (state_q == DATA) && !se0 && (ones_q != 3'(MAX_ONES));
    assign asm_clear = !rx_en || (state_q != DATA);

    usb_rx_byte_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (asm_shift),
        .clear     (asm_clear),
        .bit_in    (bit_in),
        .byte_out  (asm_byte),
        .byte_done (asm_done),
        .bit_cnt   (asm_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            zcnt_q       <= '0;
            ones_q       <= '0;
            se0cnt_q     <= '0;
            err_se0_q    <= 1'b0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            err_stuff_q  <= 1'b0;
            err_len_q    <= 1'b0;
            cnt_q        <= '0;
        end else if (!rx_en) begin
            state_q      <= IDLE;
            zcnt_q       <= '0;
            ones_q       <= '0;
            se0cnt_q     <= '0;
            err_se0_q    <= 1'b0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            err_stuff_q  <= 1'b0;
            err_len_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            byte_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            if (bit_valid) begin
                case (state_q)
                    IDLE: if (!se0 && !bit_in) begin
                        state_q     <= SYNC;
                        zcnt_q      <= 3'd1;
                        err_stuff_q <= 1'b0;
                        err_len_q   <= 1'b0;
                        cnt_q       <= '0;
                    end
                    SYNC: begin
                        if (se0) state_q <= IDLE;
                        else if (!bit_in) begin
                            if (zcnt_q == 3'(SYNC_MAX_ZEROS)) state_q <= IDLE;
                            else zcnt_q <= zcnt_q + 3'd1;
                        end else if (zcnt_q >= 3'(SYNC_MIN_ZEROS)) begin
                            state_q <= DATA;
                            ones_q  <= '0;
                        end else state_q <= IDLE;
                    end
                    DATA: begin
                        if (se0) begin
                            if (asm_cnt == 3'd0) begin
                                state_q  <= EOP;
                                se0cnt_q <= 2'd1;
                            end else begin
                                err_len_q <= 1'b1;
                                err_se0_q <= 1'b0;
                                state_q   <= ERR;
                            end
                        end else if (ones_q == 3'(MAX_ONES)) begin
                            if (bit_in) begin
                                err_stuff_q <= 1'b1;
                                err_se0_q   <= 1'b0;
                                state_q     <= ERR;
                            end else ones_q <= '0;
                        end else begin
                            ones_q <= bit_in ? ones_q + 3'd1 : 3'd0;
                            if (asm_done) begin
                                if (cnt_q == CNT_W'(MAX_BYTES)) begin
                                    err_len_q <= 1'b1;
                                    err_se0_q <= 1'b0;
                                    state_q   <= ERR;
                                end else begin
                                    byte_out_q   <= asm_byte;
                                    byte_valid_q <= 1'b1;
                                    cnt_q        <= cnt_q + 1'b1;
                                end
                            end
                        end
                    end
                    EOP: begin
                        if (se0) begin
                            if (se0cnt_q != 2'd3) se0cnt_q <= se0cnt_q + 2'd1;
                        end else if (se0cnt_q >= 2'(EOP_MIN_SE0)) begin
                            pkt_done_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            err_len_q <= 1'b1;
                            err_se0_q <= 1'b0;
                            state_q   <= ERR;
                        end
                    end
                    ERR: begin
                        // Leave only after the line has gone SE0 and back to idle while in ERR.
                        if (se0) err_se0_q <= 1'b1;
                        else if (err_se0_q) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign en_unstuff = (state_q == DATA);
    assign pkt_active = (state_q == DATA) || (state_q == EOP);
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign pkt_done   = pkt_done_q;
    assign err_stuff  = err_stuff_q;
    assign err_len    = err_len_q;
    assign byte_count = cnt_q;
endmodule

// File: tb/tb_usb_rx_sequencer.sv
// Scoreboarded bench for usb_rx_sequencer: default instance plus a MAX_BYTES=4 instance on the same line.
module tb_usb_rx_sequencer;
    import usb_sie_pkg::*;

    logic clk = 1'b0, rst = 1'b0, rx_en = 1'b0, bit_valid = 1'b0, bit_in = 1'b0, se0 = 1'b0;

    logic       en_unstuff, byte_valid, pkt_active, pkt_done, err_stuff, err_len;
    logic [7:0] byte_out;
    logic [6:0] byte_count;
    logic       en_unstuff4, byte_valid4, pkt_active4, pkt_done4, err_stuff4, err_len4;
    logic [7:0] byte_out4;
    logic [2:0] byte_count4;

    int   n_checks = 0, n_errors = 0;
    int   pd_cnt = 0, pd4_cnt = 0, bv4_cnt = 0, tx_ones = 0;
    logic [7:0] sb_q[$];

    usb_rx_sequencer dut (
        .clk(clk), .rst(rst), .rx_en(rx_en), .bit_valid(bit_valid), .bit_in(bit_in), .se0(se0),
        .en_unstuff(en_unstuff), .byte_out(byte_out), .byte_valid(byte_valid),
        .pkt_active(pkt_active), .pkt_done(pkt_done), .err_stuff(err_stuff),
        .err_len(err_len), .byte_count(byte_count)
    );

    usb_rx_sequencer #(.MAX_BYTES(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .rx_en(rx_en), .bit_valid(bit_valid), .bit_in(bit_in), .se0(se0),
        .en_unstuff(en_unstuff4), .byte_out(byte_out4), .byte_valid(byte_valid4),
        .pkt_active(pkt_active4), .pkt_done(pkt_done4), .err_stuff(err_stuff4),
        .err_len(err_len4), .byte_count(byte_count4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Pop one expected byte per byte_valid pulse; strobe must have been on the edge that raised it.
    always @(posedge clk) begin
        logic        strobe;
        logic [31:0] exp;
        strobe = bit_valid;
        #1;
        if (byte_valid) begin
            if (sb_q.size() != 0) exp = 32'(sb_q.pop_front());
            else exp = 32'hDEAD_BEEF;
            check("byte", 32'(byte_out), exp);
            check("byte_lat", 32'(strobe), 32'd1);
        end
        if (pkt_done) pd_cnt++;
        if (pkt_done4) pd4_cnt++;
        if (byte_valid4) bv4_cnt++;
    end

    task automatic send_bit(input logic b, input logic s);
        @(negedge clk);
        bit_in = b; se0 = s; bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        tx_ones = 0;
    endtask

    task automatic send_data_bit(input logic b);
        send_bit(b, 1'b0);
        if (b) begin
            tx_ones++;
            if (tx_ones == MAX_ONES) begin
                send_bit(1'b0, 1'b0);
                tx_ones = 0;
            end
        end else tx_ones = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        sb_q.push_back(b);
        for (int i = 0; i < 8; i++) send_data_bit(b[i]);
    endtask

    task automatic send_eop();
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
    endtask

    initial begin
        int pd0, pd40, bv40;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_byte_out", 32'(byte_out), 32'd0);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_pkt_active", 32'(pkt_active), 32'd0);
        check("rst_en_unstuff", 32'(en_unstuff), 32'd0);
        check("rst_errs", 32'({err_stuff, err_len}), 32'd0);
        check("rst_byte_count", 32'(byte_count), 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rx_en = 1'b1;

        // basic two-byte packet
        pd0 = pd_cnt;
        send_sync();
        check("sync_en_unstuff", 32'(en_unstuff), 32'd1);
        check("sync_pkt_active", 32'(pkt_active), 32'd1);
        send_byte(8'hC3);
        send_byte(8'hA5);
        check("p1_byte_count", 32'(byte_count), 32'd2);
        send_eop();
        check("p1_pkt_done", 32'(pd_cnt - pd0), 32'd1);
        check("p1_state", 32'(dut.state_q), 32'(IDLE));
        check("p1_pkt_active", 32'(pkt_active), 32'd0);

        // stuffed 0xFF 0xFF
        pd0 = pd_cnt;
        send_sync();
        send_byte(8'hFF);
        send_byte(8'hFF);
        check("p2_byte_count", 32'(byte_count), 32'd2);
        check("p2_err_stuff", 32'(err_stuff), 32'd0);
        send_eop();
        check("p2_pkt_done", 32'(pd_cnt - pd0), 32'd1);

        // seven ones -> stuff error
        pd0 = pd_cnt;
        send_sync();
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        check("p3_err_stuff", 32'(err_stuff), 32'd1);
        check("p3_state", 32'(dut.state_q), 32'(ERR));
        check("p3_pkt_active", 32'(pkt_active), 32'd0);
        send_eop();
        check("p3_err_idle", 32'(dut.state_q), 32'(IDLE));
        check("p3_err_held", 32'(err_stuff), 32'd1);
        check("p3_no_done", 32'(pd_cnt - pd0), 32'd0);
        send_sync();
        check("p3_err_cleared", 32'(err_stuff), 32'd0);
        send_byte(8'h5A);
        send_eop();
        check("p3_recover_done", 32'(pd_cnt - pd0), 32'd1);

        // SE0 after three bits
        pd0 = pd_cnt;
        send_sync();
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        check("p4_err_len", 32'(err_len), 32'd1);
        check("p4_state", 32'(dut.state_q), 32'(ERR));
        send_eop();
        check("p4_idle", 32'(dut.state_q), 32'(IDLE));

        // single-bit SE0 then J
        send_sync();
        check("p4b_len_cleared", 32'(err_len), 32'd0);
        send_byte(8'h12);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        check("p4b_err_len", 32'(err_len), 32'd1);
        check("p4b_state", 32'(dut.state_q), 32'(ERR));
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        check("p4b_idle", 32'(dut.state_q), 32'(IDLE));
        check("p4_no_done", 32'(pd_cnt - pd0), 32'd0);

        // five bytes: MAX_BYTES=4 instance overflows
        pd0 = pd_cnt; pd40 = pd4_cnt; bv40 = bv4_cnt;
        send_sync();
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        check("p5_bv4", 32'(bv4_cnt - bv40), 32'd4);
        check("p5_err_len4", 32'(err_len4), 32'd1);
        check("p5_state4", 32'(dut4.state_q), 32'(ERR));
        check("p5_byte_count", 32'(byte_count), 32'd5);
        check("p5_err_len", 32'(err_len), 32'd0);
        send_eop();
        check("p5_pkt_done", 32'(pd_cnt - pd0), 32'd1);
        check("p5_no_done4", 32'(pd4_cnt - pd40), 32'd0);
        check("p5_idle4", 32'(dut4.state_q), 32'(IDLE));

        // rx_en dropped mid-byte
        pd0 = pd_cnt;
        send_sync();
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        @(negedge clk);
        rx_en = 1'b0;
        @(posedge clk);
        #1;
        check("p6_state", 32'(dut.state_q), 32'(IDLE));
        check("p6_outputs", 32'({en_unstuff, pkt_active, byte_valid, pkt_done, err_stuff, err_len}), 32'd0);
        check("p6_byte_out", 32'(byte_out), 32'd0);
        check("p6_byte_count", 32'(byte_count), 32'd0);
        @(negedge clk);
        rx_en = 1'b1;
        send_eop();
        check("p6_no_done", 32'(pd_cnt - pd0), 32'd0);

        // reset mid-packet
        send_sync();
        send_byte(8'h77);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("p7_state", 32'(dut.state_q), 32'(IDLE));
        check("p7_byte_out", 32'(byte_out), 32'd0);
        check("p7_byte_count", 32'(byte_count), 32'd0);
        check("p7_pkt_active", 32'(pkt_active), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send_eop();
        check("p7_no_done", 32'(pd_cnt - pd0), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/usb_rx_sequencer.md
USB_RX_SEQUENCER -- requirements
Module: usb_rx_sequencer

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 64, the maximum number of payload bytes per packet including PID.
REQ-002 SHALL have parameter CNT_W, default 7, the width of byte_count; CNT_W SHALL be at least $clog2(MAX_BYTES+1).
REQ-003 SHALL have port clk  in  1  single receive clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_en  in  1  receiver enable.
REQ-006 SHALL have port bit_valid  in  1  one-cycle strobe per recovered bit time.
REQ-007 SHALL have port bit_in  in  1  NRZI-decoded bit (1 = no transition), sampled only with bit_valid.
REQ-008 SHALL have port se0  in  1  line single-ended-zero, sampled only with bit_valid.
REQ-009 SHALL have port en_unstuff  out  1  enable to the downstream unstuff datapath.
REQ-010 SHALL have ports byte_out  out  8  (assembled byte, LSB received first) and byte_valid  out  1  (one-cycle byte strobe).
REQ-011 SHALL have ports pkt_active  out  1  (packet in progress) and pkt_done  out  1  (one-cycle good-EOP pulse).
REQ-012 SHALL have ports err_stuff  out  1  and err_len  out  1  (sticky error flags) and byte_count  out  CNT_W  (bytes in current packet).

Function
REQ-013 SHALL implement the FSM states IDLE, SYNC, DATA, EOP and ERR; each transition SHALL occur only on a cycle with bit_valid=1, except where REQ-025 applies.
REQ-014 IDLE: rx_en=1, se0=0 and bit_in=0 SHALL go to SYNC with zero count=1, clear err_stuff, err_len and byte_count.
REQ-015 SYNC: bit_in=0 SHALL increment the zero count; more than 7 zeros or se0=1 SHALL go to IDLE.
REQ-016 SYNC: bit_in=1 with zero count 6 or 7 SHALL go to DATA; bit_in=1 with zero count below 6 SHALL go to IDLE.
REQ-017 DATA: en_unstuff and pkt_active SHALL be 1; the ones counter and the bit counter SHALL start at 0.
REQ-018 DATA, ones count=6: bit_in=0 SHALL be discarded as a stuffed bit and clear the ones count; bit_in=1 SHALL set err_stuff and go to ERR.
REQ-019 DATA, ones count<6: bit_in SHALL shift into the MSB of the shift register (shift right), increment the bit count, and increment the ones count when 1 or clear it when 0.
REQ-020 The 8th data bit SHALL cause byte_out=shift register and byte_valid=1 on the next clock, increment byte_count and reset the bit count to 0; latency from the strobe SHALL be exactly 1 cycle.
REQ-021 A byte completing when byte_count=MAX_BYTES SHALL set err_len, SHALL NOT assert byte_valid, and SHALL go to ERR.
REQ-022 DATA, se0=1: se0 SHALL take priority over bit_in; a bit count of 0 SHALL go to EOP with se0 count=1, and a nonzero bit count SHALL set err_len and go to ERR.
REQ-023 EOP: se0=1 SHALL increment the se0 count, saturating at 3; se0=0 with se0 count≥2 SHALL pulse pkt_done for 1 cycle and go to IDLE; se0=0 with se0 count=1 SHALL set err_len and go to ERR.
REQ-024 ERR: pkt_active SHALL be 0; ERR SHALL wait for se0=1 followed by a se0=0 strobe, then go to IDLE, with the error flags held.
REQ-025 rx_en=0 in any state SHALL go to IDLE on the next clock regardless of bit_valid, clear the counters and shift register, and suppress pkt_done.
REQ-026 All outputs SHALL be registered; en_unstuff and pkt_active SHALL be decoded from the registered state.

Reset
REQ-027 rst=0 SHALL immediately force state IDLE and set every counter, shift register and output to 0, including byte_out.
REQ-028 Reset deassertion SHALL take effect on the first rising clk edge with rst=1; reset mid-packet SHALL drop the packet without pkt_done.

Structure
REQ-029 Package usb_sie_pkg SHALL hold the state enum and the constants SYNC_MIN_ZEROS=6, SYNC_MAX_ZEROS=7, MAX_ONES=6 and EOP_MIN_SE0=2.
REQ-030 Byte shift register and bit counter SHALL be a sub-module usb_rx_byte_assembler with shift_en, clear, byte_out and byte_done.

Verification
REQ-031 Sync 0000000 1, then bytes 0xC3 and 0xA5, then two SE0 and J -> byte_valid twice with 0xC3 then 0xA5, byte_count=2, then one pkt_done pulse.
REQ-032 Payload 0xFF 0xFF containing the stuffed bit after six ones -> bytes 0xFF, 0xFF with the stuffed bit dropped and no error.
REQ-033 Seven consecutive ones in DATA -> err_stuff=1, state ERR, pkt_done never asserted, err_stuff cleared at the next sync.
REQ-034 SE0 after 3 bits of a byte -> err_len=1, state ERR; single-bit SE0 then J -> err_len=1.
REQ-035 MAX_BYTES=4 with 5 bytes sent -> 4 byte_valid pulses, then err_len=1.
REQ-036 rx_en dropped mid-byte, and rst asserted mid-packet -> IDLE on the next clock, all outputs 0, no pkt_done.
